// File: rtl/cpu_pkg.sv
// Shared encodings for the 16-bit multicycle CPU: opcodes, ALU ops,
// datapath mux selects and the control FSM state type.
package cpu_pkg;

    localparam logic [3:0] OP_R    = 4'b0000;
    localparam logic [3:0] OP_ADDI = 4'b0001;
    localparam logic [3:0] OP_LW   = 4'b0010;
    localparam logic [3:0] OP_SW   = 4'b0011;
    localparam logic [3:0] OP_BEQ  = 4'b0100;
    localparam logic [3:0] OP_JMP  = 4'b0101;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    localparam logic [1:0] SRC_B_REG = 2'b00;
    localparam logic [1:0] SRC_B_ONE = 2'b01;
    localparam logic [1:0] SRC_B_IMM = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC_R,
        S_R_WB,
        S_EXEC_I,
        S_I_WB,
        S_MEM_ADDR,
        S_MEM_RD,
        S_MEM_WB,
        S_MEM_WR,
        S_BRANCH,
        S_JUMP
    } state_t;

endpackage

// File: rtl/mc_control.sv
// Multicycle control FSM: sequences fetch/decode/execute/memory/writeback
// and drives the datapath selects, ALU function and memory handshake.
//
// state      | meaning
// S_FETCH    | read instruction at PC, PC <= PC+1 when memory is ready
// S_DECODE   | compute branch target into ALUOut, dispatch on opcode
// S_EXEC_R   | ALU A op B with op = funct
// S_R_WB     | write ALUOut to IR[5:3]
// S_EXEC_I   | ALU A + imm
// S_I_WB     | write ALUOut to IR[8:6]
// S_MEM_ADDR | ALU A + imm as load/store address
// S_MEM_RD   | data read at ALUOut, waits for mem_ready
// S_MEM_WB   | write MDR to IR[8:6]
// S_MEM_WR   | data write at ALUOut, waits for mem_ready
// S_BRANCH   | compare A - B, take branch target when zero
// S_JUMP     | PC <= {PC[15:12], IR[11:0]}
module mc_control
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] opcode,
    input  logic [2:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_read,
    output logic       mem_write,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_control,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       instr_done,
    output logic       illegal
);

    state_t state, state_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_FETCH:    if (mem_ready) state_next = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_R:          state_next = S_EXEC_R;
                    OP_ADDI:       state_next = S_EXEC_I;
                    OP_LW, OP_SW:  state_next = S_MEM_ADDR;
                    OP_BEQ:        state_next = S_BRANCH;
                    OP_JMP:        state_next = S_JUMP;
                    default:       state_next = S_FETCH;
                endcase
            end
            S_EXEC_R:   state_next = S_R_WB;
            S_EXEC_I:   state_next = S_I_WB;
            S_MEM_ADDR: begin
                if (opcode == OP_LW)      state_next = S_MEM_RD;
                else if (opcode == OP_SW) state_next = S_MEM_WR;
                else                      state_next = S_FETCH;
            end
            S_MEM_RD:   if (mem_ready) state_next = S_MEM_WB;
            S_MEM_WR:   if (mem_ready) state_next = S_FETCH;
            S_R_WB, S_I_WB, S_MEM_WB, S_BRANCH, S_JUMP:
                        state_next = S_FETCH;
            default:    state_next = S_FETCH;
        endcase
    end

    always_comb begin
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        iord        = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        pc_src      = PC_SRC_ALU;
        alu_src_a   = 1'b0;
        alu_src_b   = SRC_B_REG;
        alu_control = ALU_ADD;
        reg_write   = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        instr_done  = 1'b0;
        illegal     = 1'b0;
        case (state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRC_B_ONE;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: begin
                alu_src_b = SRC_B_IMM;
                if (opcode > OP_JMP) begin
                    illegal    = 1'b1;
                    instr_done = 1'b1;
                end
            end
            S_EXEC_R: begin
                alu_src_a   = 1'b1;
                alu_control = funct;
            end
            S_R_WB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                instr_done = 1'b1;
            end
            S_EXEC_I, S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRC_B_IMM;
            end
            S_I_WB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
            end
            S_MEM_WR: begin
                mem_write  = 1'b1;
                iord       = 1'b1;
                instr_done = mem_ready;
            end
            S_BRANCH: begin
                alu_src_a   = 1'b1;
                alu_control = ALU_SUB;
                pc_src      = PC_SRC_ALUOUT;
                pc_write    = zero;
                instr_done  = 1'b1;
            end
            S_JUMP: begin
                pc_write   = 1'b1;
                pc_src     = PC_SRC_JUMP;
                instr_done = 1'b1;
            end
            default: ;
        endcase
        // The state register sits at FETCH during reset; mask so nothing is
        // requested until rst_n releases, and drop any stalled access at once.
        if (!rst_n) begin
            mem_read    = 1'b0;
            mem_write   = 1'b0;
            iord        = 1'b0;
            ir_write    = 1'b0;
            pc_write    = 1'b0;
            pc_src      = 2'b00;
            alu_src_a   = 1'b0;
            alu_src_b   = 2'b00;
            alu_control = 3'b000;
            reg_write   = 1'b0;
            reg_dst     = 1'b0;
            mem_to_reg  = 1'b0;
            instr_done  = 1'b0;
            illegal     = 1'b0;
        end
    end

endmodule
